// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - MEM stage with valid/ready data-memory request, variable-latency loads, load/store lane logic
// Optional feature macro: MEM_MISALIGN_EN (misaligned half/word trapped, adds excp_ale / excp_badvaddr).
module mem_stage_hs #(
  parameter int PC_W      = 32,
  parameter int RF_AW     = 5,
  parameter int STALL_W   = 6,
  parameter int STAGE_IDX = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic               ex_mem_en,
  input  logic               ex_mem_we,
  input  logic [1:0]         ex_mem_size,
  input  logic               ex_mem_sext,
  input  logic [31:0]        ex_store_data,
  input  logic               ex_rf_we,
  input  logic [RF_AW-1:0]   ex_rf_waddr,
  input  logic [31:0]        ex_result,
  output logic               dreq_valid,
  input  logic               dreq_ready,
  output logic [31:0]        dreq_addr,
  output logic [3:0]         dreq_wstrb,
  output logic [31:0]        dreq_wdata,
  input  logic               drsp_valid,
  input  logic [31:0]        drsp_rdata,
  output logic               stall_req,
`ifdef MEM_MISALIGN_EN
  output logic               excp_ale,
  output logic [31:0]        excp_badvaddr,
`endif
  output logic [PC_W-1:0]    wb_pc,
  output logic               wb_rf_we,
  output logic [RF_AW-1:0]   wb_rf_waddr,
  output logic [31:0]        wb_rf_wdata,
  output logic               fwd_rf_we,
  output logic [RF_AW-1:0]   fwd_rf_waddr,
  output logic [31:0]        fwd_rf_wdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_RSP   = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [PC_W-1:0]  pc_q;
  logic             mem_en_q, mem_we_q, sext_q, rf_we_q;
  logic [1:0]       size_q;
  logic [31:0]      sdata_q, result_q, load_q;
  logic [RF_AW-1:0] waddr_q;
  logic [2:0]       state_q, state_d;
  logic             hold, bubble, hs, misalign, load_done;
  logic [3:0]       wstrb;
  logic [31:0]      wdata, ext;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;

  assign hold   = stall[STAGE_IDX] & stall[STAGE_IDX+1];
  assign bubble = stall[STAGE_IDX] & ~stall[STAGE_IDX+1];

  always_ff @(posedge clk) begin
    if (rst || flush || bubble) begin
      pc_q     <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      size_q   <= 2'd0;
      sext_q   <= 1'b0;
      sdata_q  <= '0;
      rf_we_q  <= 1'b0;
      waddr_q  <= '0;
      result_q <= '0;
    end else if (!stall[STAGE_IDX]) begin
      pc_q     <= ex_pc;
      mem_en_q <= ex_mem_en;
      mem_we_q <= ex_mem_we;
      size_q   <= ex_mem_size;
      sext_q   <= ex_mem_sext;
      sdata_q  <= ex_store_data;
      rf_we_q  <= ex_rf_we;
      waddr_q  <= ex_rf_waddr;
      result_q <= ex_result;
    end
  end

`ifdef MEM_MISALIGN_EN
  assign misalign      = mem_en_q & (((size_q == 2'd1) & result_q[0]) | (size_q[1] & (|result_q[1:0])));
  assign excp_ale      = misalign;
  assign excp_badvaddr = misalign ? result_q : 32'd0;
`else
  assign misalign = 1'b0;
`endif

  // Sizes 2 and 3 both behave as a full word.
  always_comb begin
    wstrb = 4'hF;
    wdata = sdata_q;
    case (size_q)
      2'd0: begin
        wstrb = 4'b0001 << result_q[1:0];
        wdata = {4{sdata_q[7:0]}};
      end
      2'd1: begin
        wstrb = 4'b0011 << {result_q[1], 1'b0};
        wdata = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = drsp_rdata[8*result_q[1:0] +: 8];
    half_sel = result_q[1] ? drsp_rdata[31:16] : drsp_rdata[15:0];
    case (size_q)
      2'd0:    ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'd1:    ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: ext = drsp_rdata;
    endcase
  end

  assign dreq_valid = ((state_q == S_IDLE) & mem_en_q & ~misalign) | (state_q == S_REQ);
  assign dreq_addr  = {result_q[31:2], 2'b00};
  assign dreq_wstrb = mem_we_q ? wstrb : 4'b0000;
  assign dreq_wdata = wdata;
  assign hs         = dreq_valid & dreq_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_en_q) begin
          if (misalign)  state_d = S_DONE;
          else if (hs)   state_d = mem_we_q ? S_DONE : S_RSP;
          else           state_d = S_REQ;
        end
      end
      S_REQ:   if (hs) state_d = mem_we_q ? S_DONE : S_RSP;
      S_RSP:   if (drsp_valid) state_d = S_DONE;
      S_DONE:  if (!hold) state_d = S_IDLE;
      S_DRAIN: if (drsp_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A load already accepted by memory still owes a response that must be swallowed.
    if (flush && state_q != S_DRAIN) begin
      if ((state_q == S_RSP && !drsp_valid) || (hs && !mem_we_q)) state_d = S_DRAIN;
      else                                                         state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_RSP && drsp_valid) load_q <= ext;
    end
  end

  assign stall_req = (mem_en_q & ((state_q == S_IDLE) | (state_q == S_REQ) | (state_q == S_RSP)))
                   | (state_q == S_DRAIN);
  assign load_done = mem_en_q & ~mem_we_q & ~misalign & (state_q == S_DONE);

  assign wb_pc        = pc_q;
  assign wb_rf_we     = rf_we_q & ~stall_req & ~misalign;
  assign wb_rf_waddr  = waddr_q;
  assign wb_rf_wdata  = load_done ? load_q : result_q;
  assign fwd_rf_we    = wb_rf_we;
  assign fwd_rf_waddr = wb_rf_waddr;
  assign fwd_rf_wdata = wb_rf_wdata;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - self-checking bench for mem_stage_hs (table vectors, random vs reference model, flush corners)
module tb_mem_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] ex_pc, ex_store_data, ex_result;
  logic        ex_mem_en, ex_mem_we, ex_mem_sext, ex_rf_we;
  logic [1:0]  ex_mem_size;
  logic [4:0]  ex_rf_waddr;
  logic        dreq_valid, dreq_ready, drsp_valid, stall_req;
  logic [31:0] dreq_addr, dreq_wdata, drsp_rdata;
  logic [3:0]  dreq_wstrb;
  logic [31:0] wb_pc, wb_rf_wdata, fwd_rf_wdata;
  logic        wb_rf_we, fwd_rf_we;
  logic [4:0]  wb_rf_waddr, fwd_rf_waddr;
`ifdef MEM_MISALIGN_EN
  logic        excp_ale;
  logic [31:0] excp_badvaddr;
`endif

  always #5 clk = ~clk;

  // Stall controller: this stage's request freezes itself and everything upstream.
  assign stall = stall_req ? 6'b011111 : 6'b000000;

  mem_stage_hs dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_pc(ex_pc), .ex_mem_en(ex_mem_en), .ex_mem_we(ex_mem_we), .ex_mem_size(ex_mem_size),
    .ex_mem_sext(ex_mem_sext), .ex_store_data(ex_store_data), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_wstrb(dreq_wstrb), .dreq_wdata(dreq_wdata),
    .drsp_valid(drsp_valid), .drsp_rdata(drsp_rdata), .stall_req(stall_req),
`ifdef MEM_MISALIGN_EN
    .excp_ale(excp_ale), .excp_badvaddr(excp_badvaddr),
`endif
    .wb_pc(wb_pc), .wb_rf_we(wb_rf_we), .wb_rf_waddr(wb_rf_waddr), .wb_rf_wdata(wb_rf_wdata),
    .fwd_rf_we(fwd_rf_we), .fwd_rf_waddr(fwd_rf_waddr), .fwd_rf_wdata(fwd_rf_wdata)
  );

  typedef struct {
    logic [31:0] pc;
    logic        mem_en, we, sext, rf_we;
    logic [1:0]  size;
    logic [31:0] sdata, result, rdata;
    logic [4:0]  waddr;
    int          rdly, rlat;
    logic [31:0] exp_wdata, exp_addr, exp_dwdata;
    logic [3:0]  exp_wstrb;
    int          exp_stall;
    logic        exp_we, exp_dreq, exp_ale;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk32(nm, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic vec_t mkv(input logic [31:0] pc, input logic mem_en, input logic we,
                               input logic [1:0] size, input logic sext, input logic [31:0] sdata,
                               input logic rf_we, input logic [4:0] waddr, input logic [31:0] result,
                               input int rdly, input int rlat, input logic [31:0] rdata,
                               input logic [31:0] exp_wdata, input logic [31:0] exp_addr,
                               input logic [3:0] exp_wstrb, input logic [31:0] exp_dwdata,
                               input int exp_stall, input logic exp_we, input logic exp_dreq);
    vec_t v;
    v.pc = pc; v.mem_en = mem_en; v.we = we; v.size = size; v.sext = sext; v.sdata = sdata;
    v.rf_we = rf_we; v.waddr = waddr; v.result = result; v.rdly = rdly; v.rlat = rlat; v.rdata = rdata;
    v.exp_wdata = exp_wdata; v.exp_addr = exp_addr; v.exp_wstrb = exp_wstrb; v.exp_dwdata = exp_dwdata;
    v.exp_stall = exp_stall; v.exp_we = exp_we; v.exp_dreq = exp_dreq; v.exp_ale = 1'b0;
    return v;
  endfunction

  // Reference: pick the addressed bytes out of the word, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int nb, input logic sx);
    logic [31:0] v, m;
    v = w >> (8 * off);
    if (nb == 4) return v;
    m = (32'h1 << (8 * nb)) - 32'h1;
    v = v & m;
    if (sx && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic vec_t ref_vec(input vec_t v);
    int nb, off;
    logic mis;
    nb  = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
    off = (v.size == 2'd0) ? int'(v.result[1:0]) : (v.size == 2'd1) ? 2 * int'(v.result[1]) : 0;
    mis = 1'b0;
`ifdef MEM_MISALIGN_EN
    mis = v.mem_en && ((nb == 2 && v.result[0]) || (nb == 4 && v.result[1:0] != 2'b00));
`endif
    v.exp_addr  = v.result & ~32'h3;
    v.exp_wstrb = (v.mem_en && v.we) ? 4'(((1 << nb) - 1) << off) : 4'h0;
    for (int i = 0; i < 4; i++) v.exp_dwdata[8*i +: 8] = v.sdata[8*(i % nb) +: 8];
    v.exp_wdata = (v.mem_en && !v.we && !mis) ? ref_load(v.rdata, off, nb, v.sext) : v.result;
    v.exp_stall = !v.mem_en ? 0 : mis ? 1 : v.we ? v.rdly + 1 : v.rdly + 1 + v.rlat;
    v.exp_we    = v.rf_we && !mis;
    v.exp_dreq  = v.mem_en && !mis;
    v.exp_ale   = mis;
    return v;
  endfunction

  task automatic drive_ex(input vec_t v);
    ex_pc = v.pc; ex_mem_en = v.mem_en; ex_mem_we = v.we; ex_mem_size = v.size;
    ex_mem_sext = v.sext; ex_store_data = v.sdata; ex_rf_we = v.rf_we;
    ex_rf_waddr = v.waddr; ex_result = v.result;
  endtask

  task automatic drive_nop();
    ex_pc = 32'd0; ex_mem_en = 1'b0; ex_mem_we = 1'b0; ex_mem_size = 2'd0;
    ex_mem_sext = 1'b0; ex_store_data = 32'd0; ex_rf_we = 1'b0;
    ex_rf_waddr = 5'd0; ex_result = 32'd0;
  endtask

  // Entered at a negedge where the stage is not stalling; returns at the completion negedge.
  task automatic run_instr(input vec_t v, input string nm);
    int  nvalid, hs_k, stall_n, we_n;
    bit  done;
    nvalid = 0; hs_k = -1; stall_n = 0; we_n = 0; done = 0;
    drive_ex(v);
    @(negedge clk);
    drive_nop();
    for (int k = 0; k < 300; k++) begin
      if (dreq_valid) begin
        chk32({nm, " dreq_addr"}, dreq_addr, v.exp_addr);
        chk32({nm, " dreq_wstrb"}, {28'd0, dreq_wstrb}, {28'd0, v.exp_wstrb});
        if (v.we) chk32({nm, " dreq_wdata"}, dreq_wdata, v.exp_dwdata);
      end
      if (wb_rf_we) we_n++;
      if (!stall_req) begin
        done = 1;
        break;
      end
      stall_n++;
      dreq_ready = dreq_valid && hs_k < 0 && nvalid >= v.rdly;
      if (dreq_ready) hs_k = k;
      if (dreq_valid) nvalid++;
      drsp_valid = v.mem_en && !v.we && hs_k >= 0 && k == hs_k + v.rlat;
      drsp_rdata = drsp_valid ? v.rdata : $urandom;
      @(negedge clk);
    end
    dreq_ready = 1'b0;
    drsp_valid = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL %s timeout: stall_req still high after 300 cycles, required to drop", nm);
    end else begin
      chk32({nm, " stall_cycles"}, stall_n, v.exp_stall);
      chk1({nm, " request_issued"}, hs_k >= 0, v.exp_dreq);
      chk1({nm, " wb_rf_we"}, wb_rf_we, v.exp_we);
      chk32({nm, " we_pulses"}, we_n, v.exp_we ? 1 : 0);
      chk32({nm, " wb_rf_wdata"}, wb_rf_wdata, v.exp_wdata);
      chk32({nm, " fwd_rf_wdata"}, fwd_rf_wdata, v.exp_wdata);
      chk32({nm, " wb_rf_waddr"}, {27'd0, wb_rf_waddr}, {27'd0, v.waddr});
      chk32({nm, " wb_pc"}, wb_pc, v.pc);
`ifdef MEM_MISALIGN_EN
      chk1({nm, " excp_ale"}, excp_ale, v.exp_ale);
`endif
    end
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    //            pc        men we sz sx sdata          rfwe wa result        rdly rlat rdata          exp_wdata      exp_addr       wstrb  exp_dwdata    stall we dreq
    tbl[0] = mkv(32'h100, 0, 0, 0, 0, 32'h0,         1, 3, 32'h0000_1234, 0, 1, 32'h0,         32'h0000_1234, 32'h0000_1234, 4'h0, 32'h0,         0, 1, 0);
    tbl[1] = mkv(32'h104, 1, 0, 0, 1, 32'h0,         1, 4, 32'h0000_1003, 0, 2, 32'h80FF_EE11, 32'hFFFF_FF80, 32'h0000_1000, 4'h0, 32'h0,         3, 1, 1);
    tbl[2] = mkv(32'h108, 1, 0, 0, 0, 32'h0,         1, 5, 32'h0000_1003, 1, 1, 32'h80FF_EE11, 32'h0000_0080, 32'h0000_1000, 4'h0, 32'h0,         3, 1, 1);
    tbl[3] = mkv(32'h10C, 1, 1, 1, 0, 32'h0000_ABCD, 0, 0, 32'h0000_2002, 3, 1, 32'h0,         32'h0000_2002, 32'h0000_2000, 4'hC, 32'hABCD_ABCD, 4, 0, 1);
    tbl[4] = mkv(32'h110, 1, 0, 2, 0, 32'h0,         1, 6, 32'h0000_4000, 0, 4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_4000, 4'h0, 32'h0,         5, 1, 1);
    tbl[5] = mkv(32'h114, 1, 0, 1, 1, 32'h0,         1, 7, 32'h0000_1002, 2, 3, 32'h80FF_EE11, 32'hFFFF_80FF, 32'h0000_1000, 4'h0, 32'h0,         6, 1, 1);
    tbl[6] = mkv(32'h118, 1, 0, 1, 0, 32'h0,         1, 8, 32'h0000_1000, 0, 1, 32'h80FF_EE11, 32'h0000_EE11, 32'h0000_1000, 4'h0, 32'h0,         2, 1, 1);
    tbl[7] = mkv(32'h11C, 1, 1, 0, 0, 32'h1234_5678, 0, 0, 32'h0000_5001, 0, 1, 32'h0,         32'h0000_5001, 32'h0000_5000, 4'h2, 32'h7878_7878, 1, 0, 1);
    tbl[8] = mkv(32'h120, 1, 1, 2, 0, 32'hCAFE_F00D, 0, 0, 32'h0000_6004, 1, 1, 32'h0,         32'h0000_6004, 32'h0000_6004, 4'hF, 32'hCAFE_F00D, 2, 0, 1);
    tbl[9] = mkv(32'h124, 0, 0, 0, 0, 32'h0,         0, 9, 32'hFFFF_0000, 0, 1, 32'h0,         32'hFFFF_0000, 32'hFFFF_0000, 4'h0, 32'h0,         0, 0, 0);

    rst = 1'b1; flush = 1'b0; dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = 32'd0;
    drive_ex(tbl[4]);
    repeat (3) @(negedge clk);
    chk1("reset dreq_valid", dreq_valid, 1'b0);
    chk1("reset stall_req", stall_req, 1'b0);
    chk1("reset wb_rf_we", wb_rf_we, 1'b0);
    chk32("reset wb_rf_wdata", wb_rf_wdata, 32'd0);
    chk32("reset wb_pc", wb_pc, 32'd0);
    rst = 1'b0;
    drive_nop();
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_instr(tbl[i], $sformatf("vec%0d", i));

    // Flush while waiting for a load response: the late response must be dropped.
    drive_ex(mkv(32'h200, 1, 0, 2, 0, 0, 1, 10, 32'h7000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive_nop();
    chk1("rspflush req", dreq_valid, 1'b1);
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    chk1("rspflush rsp stall", stall_req, 1'b1);
    chk1("rspflush rsp no req", dreq_valid, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk1("rspflush drain stall", stall_req, 1'b1);
    chk1("rspflush drain we", wb_rf_we, 1'b0);
    @(negedge clk);
    chk1("rspflush drain stall2", stall_req, 1'b1);
    chk1("rspflush drain we2", wb_rf_we, 1'b0);
    drsp_valid = 1'b1; drsp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    drsp_valid = 1'b0;
    chk1("rspflush exit stall", stall_req, 1'b0);
    chk1("rspflush exit we", wb_rf_we, 1'b0);
    chk1("rspflush exit req", dreq_valid, 1'b0);
    run_instr(tbl[4], "after_drain_lw");

    // Flush while a store request is still waiting for ready: request withdrawn.
    drive_ex(tbl[8]);
    @(negedge clk);
    drive_nop();
    chk1("reqflush req", dreq_valid, 1'b1);
    @(negedge clk);
    chk1("reqflush req held", dreq_valid, 1'b1);
    chk32("reqflush addr held", dreq_addr, 32'h0000_6004);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk1("reqflush withdrawn", dreq_valid, 1'b0);
    chk1("reqflush no stall", stall_req, 1'b0);

`ifdef MEM_MISALIGN_EN
    drive_ex(mkv(32'h300, 1, 0, 2, 0, 0, 1, 11, 32'h3002, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive_nop();
    chk1("misalign no req", dreq_valid, 1'b0);
    chk1("misalign ale", excp_ale, 1'b1);
    chk32("misalign badvaddr", excp_badvaddr, 32'h0000_3002);
    chk1("misalign we", wb_rf_we, 1'b0);
    @(negedge clk);
    chk1("misalign done no req", dreq_valid, 1'b0);
    chk1("misalign done ale", excp_ale, 1'b1);
    chk1("misalign done we", wb_rf_we, 1'b0);
    chk1("misalign done stall", stall_req, 1'b0);
`endif

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind      = $urandom_range(0, 2);
      rv.pc     = $urandom;
      rv.mem_en = (kind != 0);
      rv.we     = (kind == 2);
      rv.size   = 2'($urandom_range(0, 2));
      rv.sext   = 1'($urandom);
      rv.sdata  = $urandom;
      rv.rf_we  = 1'($urandom);
      rv.waddr  = 5'($urandom);
      rv.result = $urandom;
      rv.rdly   = $urandom_range(0, 3);
      rv.rlat   = $urandom_range(1, 4);
      rv.rdata  = $urandom;
      run_instr(ref_vec(rv), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
